// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the pipelined MIPS datapath: owns the PC, addresses instruction
// memory and registers the fetched word into the IF/ID pipeline register.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 7
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               BranchTaken,
    input  logic [31:0]        BranchTarget,
    input  logic               Jump,
    input  logic [31:0]        JumpTarget,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [31:0]        ImemData,
    output logic [31:0]        PC,
    output logic [31:0]        IFID_Instr,
    output logic [31:0]        IFID_PCPlus4,
    output logic               IFID_Valid,
    output logic [31:0]        FetchCount,
    output logic               AlignErr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        align_err_q, align_err_d;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;
    logic        redirect;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        pc_inc          = pc_q + 32'd4;
        redirect        = BranchTaken | Jump;
        redirect_target = BranchTaken ? BranchTarget : JumpTarget;

        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        align_err_d = align_err_q;

        if (redirect) begin
            // The word fetched this cycle is wrong-path, so it becomes a bubble.
            pc_d        = {redirect_target[31:2], 2'b00};
            instr_d     = 32'h0;
            pc_plus4_d  = 32'h0;
            valid_d     = 1'b0;
            align_err_d = align_err_q | (redirect_target[1:0] != 2'b00);
        end else if (Stall) begin
            if (Flush) begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
            end
        end else begin
            pc_d = pc_inc;
            if (Flush) begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
            end else begin
                instr_d     = ImemData;
                pc_plus4_d  = pc_inc;
                valid_d     = 1'b1;
                fetch_cnt_d = sat_inc(fetch_cnt_q);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 32'h0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            align_err_q <= align_err_d;
        end
    end

    assign ImemAddr     = pc_q[IMEM_AW+1:2];
    assign PC           = pc_q;
    assign IFID_Instr   = instr_q;
    assign IFID_PCPlus4 = pc_plus4_q;
    assign IFID_Valid   = valid_q;
    assign FetchCount   = fetch_cnt_q;
    assign AlignErr     = align_err_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Vector-table bench for instruction_fetch_stage with a behavioural instruction memory.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, br, jmp;
    logic [31:0] br_tgt, jmp_tgt;
    logic [6:0]  imem_addr;
    logic [31:0] imem_data, pc, ifid_instr, ifid_pc4, fetch_cnt;
    logic        ifid_valid, align_err;
    logic [31:0] mem [128];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(7)) dut (
        .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush),
        .BranchTaken(br), .BranchTarget(br_tgt), .Jump(jmp), .JumpTarget(jmp_tgt),
        .ImemAddr(imem_addr), .ImemData(imem_data), .PC(pc),
        .IFID_Instr(ifid_instr), .IFID_PCPlus4(ifid_pc4), .IFID_Valid(ifid_valid),
        .FetchCount(fetch_cnt), .AlignErr(align_err)
    );

    typedef struct {
        logic        rst, stall, flush, br, jmp;
        logic [31:0] br_tgt, jmp_tgt;
        logic [31:0] pc, instr, pc4;
        logic        vld;
        logic [31:0] cnt;
        logic        al;
        logic [6:0]  addr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f,
                                input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic [31:0] epc, input logic [31:0] ein,
                                input logic [31:0] ep4, input logic ev,
                                input logic [31:0] ec, input logic ea, input logic [6:0] ead);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.br = b; v.br_tgt = bt;
        v.jmp = j; v.jmp_tgt = jt; v.pc = epc; v.instr = ein; v.pc4 = ep4;
        v.vld = ev; v.cnt = ec; v.al = ea; v.addr = ead;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;

        //             rst stl fls br  brtgt          jmp jtgt           PC             Instr          PC+4           V  Cnt    AE  Addr
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 32'd0,  0, 7'h00)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 32'd0,  0, 7'h00));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 32'd1,  0, 7'h01)); // 2 first fetch
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 32'd2,  0, 7'h02));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'hC,         32'h0109_5020, 32'hC,         1, 32'd3,  0, 7'h03));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          1, 32'h4,          32'h4,         32'h0,         32'h0,         0, 32'd3,  0, 7'h01)); // 5 jump back
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 32'd4,  0, 7'h02));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 32'd4,  0, 7'h02)); // 7 stall
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 32'd4,  0, 7'h02));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'hC,         32'h0109_5020, 32'hC,         1, 32'd5,  0, 7'h03));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          1, 32'h4,          32'h4,         32'h0,         32'h0,         0, 32'd5,  0, 7'h01)); // 10
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 32'd6,  0, 7'h02));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,          0, 32'h0,          32'h8,         32'h0,         32'h0,         0, 32'd6,  0, 7'h02)); // 12 stall+flush
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'hC,         32'h0109_5020, 32'hC,         1, 32'd7,  0, 7'h03));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,          0, 32'h0,          32'h10,        32'h0,         32'h0,         0, 32'd7,  0, 7'h04)); // 14 flush only
        vecs.push_back(mk(0, 0, 0, 1, 32'h40,         1, 32'h80,         32'h40,        32'h0,         32'h0,         0, 32'd7,  0, 7'h10)); // 15 br vs jmp
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h44,        32'hA000_0010, 32'h44,        1, 32'd8,  0, 7'h11));
        vecs.push_back(mk(0, 1, 1, 1, 32'h40,         1, 32'h80,         32'h40,        32'h0,         32'h0,         0, 32'd8,  0, 7'h10)); // 17 redirect+stall
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h44,        32'hA000_0010, 32'h44,        1, 32'd9,  0, 7'h11));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          1, 32'h46,         32'h44,        32'h0,         32'h0,         0, 32'd9,  1, 7'h11)); // 19 misaligned
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h48,        32'hA000_0011, 32'h48,        1, 32'd10, 1, 7'h12));
        vecs.push_back(mk(0, 0, 0, 1, 32'h80,         0, 32'h0,          32'h80,        32'h0,         32'h0,         0, 32'd10, 1, 7'h20));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h84,        32'hA000_0020, 32'h84,        1, 32'd11, 1, 7'h21));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         32'h0,         0, 32'd11, 1, 7'h7F)); // 23 wrap
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'hA000_007F, 32'h0,         1, 32'd12, 1, 7'h00));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 32'd13, 1, 7'h01));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 32'd0,  0, 7'h00)); // 26 mid-run reset
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 32'd1,  0, 7'h01));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
            br = vecs[i].br; br_tgt = vecs[i].br_tgt;
            jmp = vecs[i].jmp; jmp_tgt = vecs[i].jmp_tgt;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("pc",        i, pc,                 e.pc);
            check("ifid_instr", i, ifid_instr,        e.instr);
            check("ifid_pc4",  i, ifid_pc4,           e.pc4);
            check("ifid_valid", i, 32'(ifid_valid),   32'(e.vld));
            check("fetch_cnt", i, fetch_cnt,          e.cnt);
            check("align_err", i, 32'(align_err),     32'(e.al));
            check("imem_addr", i, 32'(imem_addr),     32'(e.addr));
        end

        // Hold Stall with no redirect: nothing in the stage may move across several edges.
        rst = 0; stall = 1; flush = 0; br = 0; jmp = 0;
        repeat (3) @(posedge clk);
        #1;
        check("long_stall_pc",  99, pc,         32'h4);
        check("long_stall_cnt", 99, fetch_cnt,  32'd1);
        check("long_stall_ins", 99, ifid_instr, 32'h2008_0001);
        stall = 0;
        @(posedge clk);
        #1;
        check("after_stall_ins", 100, ifid_instr, 32'h2009_0002);
        check("after_stall_cnt", 100, fetch_cnt,  32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
